// File: rtl/reg_file_alu_pkg.sv
// ============================================================================
// Module   : reg_file_alu_pkg
// Purpose  : Shared ALU opcode, flag bundle and default sizing for the
//            register-file/ALU pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_alu_pkg;

    localparam int c_DATA_W_DEFAULT = 8;
    localparam int c_NREGS_DEFAULT  = 16;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_alu_pipe_alu_core.sv
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational 8-op ALU with carry/borrow, signed overflow and
//            zero flags, parametrised on datapath width.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_t           i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_overflow,
    output logic              o_zero
);

    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W:0]   w_shl;
    logic [SH_W-1:0]   w_shamt;
    logic              w_slt;

    assign w_shamt = i_b[SH_W-1:0];
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    // Top bit of the widened difference is the unsigned borrow.
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    // Widened shift parks the last bit shifted out in the top position.
    assign w_shl   = {1'b0, i_a} << w_shamt;
    assign w_slt   = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: begin
                o_result   = w_sum[DATA_W-1:0];
                o_carry    = w_sum[DATA_W];
                o_overflow = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != i_a[DATA_W-1]);
            end
            ALU_SUB: begin
                o_result   = w_diff[DATA_W-1:0];
                o_carry    = w_diff[DATA_W];
                o_overflow = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != i_a[DATA_W-1]);
            end
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_slt};
            ALU_SHL: begin
                o_result = w_shl[DATA_W-1:0];
                o_carry  = w_shl[DATA_W];
            end
            ALU_SHR: o_result = i_a >> w_shamt;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/reg_file_alu_pipe.sv
// ============================================================================
// Module   : reg_file_alu_pipe
// Purpose  : Two-stage register-file/ALU pipeline (operand capture, then
//            execute + write-back). Define REG_FILE_ALU_BYPASS_EN to forward
//            the in-flight result to a dependent op issued the next cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_alu_pipe
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int NREGS  = c_NREGS_DEFAULT,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] external_data_in,
    input  logic              RegWrite,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUControl,
    output logic [DATA_W-1:0] ALUResult,
    output logic              out_valid,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);

    logic [DATA_W-1:0] r_regs [NREGS];

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    alu_op_t           r_s1_op;
    logic [ADDR_W-1:0] r_s1_wa;
    logic              r_s1_we;

    logic [DATA_W-1:0] r_result;
    alu_flags_t        r_flags;
    logic              r_out_valid;

    logic [DATA_W-1:0] w_alu_result;
    alu_flags_t        w_alu_flags;
    logic              w_fwd_a;
    logic              w_fwd_b;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    alu_core #(
        .DATA_W     (DATA_W)
    ) u_alu (
        .i_a        (r_s1_a),
        .i_b        (r_s1_b),
        .i_op       (r_s1_op),
        .o_result   (w_alu_result),
        .o_carry    (w_alu_flags.carry),
        .o_overflow (w_alu_flags.overflow),
        .o_zero     (w_alu_flags.zero)
    );

    assign w_wr_en = r_s1_valid && r_s1_we;

`ifdef REG_FILE_ALU_BYPASS_EN
    // Producer is one stage ahead and writes only at this same edge.
    assign w_fwd_a = w_wr_en && (r_s1_wa == RA1);
    assign w_fwd_b = w_wr_en && (r_s1_wa == RA2) && !ALUSrc;
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    always_comb begin
        w_op_a = r_regs[RA1];
        w_op_b = r_regs[RA2];
        if (w_fwd_a) w_op_a = w_alu_result;
        if (ALUSrc)
            w_op_b = external_data_in;
        else if (w_fwd_b)
            w_op_b = w_alu_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[r_s1_wa] <= w_alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= ALU_AND;
            r_s1_wa    <= '0;
            r_s1_we    <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= w_op_a;
                r_s1_b  <= w_op_b;
                r_s1_op <= alu_op_t'(ALUControl);
                r_s1_wa <= WA;
                r_s1_we <= RegWrite;
            end
        end
    end

    // Bubbles leave the previous result and flags on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_alu_result;
                r_flags  <= w_alu_flags;
            end
        end
    end

    assign ALUResult = r_result;
    assign out_valid = r_out_valid;
    assign zero      = r_flags.zero;
    assign carry     = r_flags.carry;
    assign overflow  = r_flags.overflow;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_alu_pipe.sv
// ============================================================================
// Module   : tb_reg_file_alu_pipe
// Purpose  : Self-checking bench: directed plus random ops against an
//            arithmetic reference model of the register file and ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_alu_pipe;

    localparam int DATA_W = 8;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;
    localparam int MODV   = 1 << DATA_W;
    localparam int HALF   = 1 << (DATA_W - 1);
`ifdef REG_FILE_ALU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [ADDR_W-1:0] RA1 = '0, RA2 = '0, WA = '0;
    logic [DATA_W-1:0] external_data_in = '0;
    logic              RegWrite = 1'b0, ALUSrc = 1'b0;
    logic [2:0]        ALUControl = '0;
    logic [DATA_W-1:0] ALUResult;
    logic              out_valid, zero, carry, overflow;

    reg_file_alu_pipe #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .RA1(RA1), .RA2(RA2), .WA(WA),
        .external_data_in(external_data_in), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .ALUResult(ALUResult), .out_valid(out_valid),
        .zero(zero), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int res;
        bit z, c, o;
        bit fx;
        int fres;
        bit fz, fc, fo;
    } exp_t;

    exp_t q[$];
    int   mem [NREGS];
    bit   pend_v, pend_we;
    int   pend_wa, pend_val;
    int   last_res;
    bit   last_z, last_c, last_o;
    bit   g_fx;
    int   g_fres;
    bit   g_fz, g_fc, g_fo;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - MODV : x;
    endfunction

    task automatic ref_alu(input int op, input int a, input int b,
                           output int r, output bit z, output bit c, output bit o);
        int s, sh;
        c = 0; o = 0;
        sh = b % DATA_W;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin
                r = (a + b) % MODV; c = (a + b) >= MODV;
                s = sgn(a) + sgn(b); o = (s >= HALF) || (s < -HALF);
            end
            3: begin
                r = (a - b + MODV) % MODV; c = a < b;
                s = sgn(a) - sgn(b); o = (s >= HALF) || (s < -HALF);
            end
            4: r = a ^ b;
            5: r = (sgn(a) < sgn(b)) ? 1 : 0;
            6: begin
                s = a * (1 << sh); r = s % MODV; c = ((s / MODV) % 2) == 1;
            end
            default: r = a / (1 << sh);
        endcase
        z = (r == 0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) mem[i] = 0;
        pend_v = 0; pend_we = 0; pend_wa = 0; pend_val = 0;
        last_res = 0; last_z = 0; last_c = 0; last_o = 0;
        q.delete();
    endtask

    task automatic check_rec(input exp_t e);
        chk("out_valid", out_valid, e.v);
        chk("result", ALUResult, e.res);
        chk("zero", zero, e.z);
        chk("carry", carry, e.c);
        chk("overflow", overflow, e.o);
        if (e.fx) begin
            chk("dir_result", ALUResult, e.fres);
            chk("dir_zero", zero, e.fz);
            chk("dir_carry", carry, e.fc);
            chk("dir_overflow", overflow, e.fo);
        end
    endtask

    task automatic expect_fixed(input int r, input bit z, input bit c, input bit o);
        g_fx = 1; g_fres = r; g_fz = z; g_fc = c; g_fo = o;
    endtask

    // One clock of stimulus: check the op issued two cycles earlier, drive a new one.
    task automatic cycle(input bit v, input int op, input int ra1, input int ra2,
                         input int wa, input int imm, input bit we, input bit src);
        exp_t e;
        int   a, b;
        @(negedge clk);
        if (q.size() >= 2) check_rec(q.pop_front());
        in_valid = v; ALUControl = op[2:0]; RA1 = ra1[ADDR_W-1:0]; RA2 = ra2[ADDR_W-1:0];
        WA = wa[ADDR_W-1:0]; external_data_in = imm[DATA_W-1:0]; RegWrite = we; ALUSrc = src;
        e.v = v; e.fx = g_fx; e.fres = g_fres; e.fz = g_fz; e.fc = g_fc; e.fo = g_fo;
        g_fx = 0;
        if (v) begin
            a = mem[ra1];
            if (BYP && pend_v && pend_we && pend_wa == ra1) a = pend_val;
            if (src) b = imm;
            else begin
                b = mem[ra2];
                if (BYP && pend_v && pend_we && pend_wa == ra2) b = pend_val;
            end
            ref_alu(op, a, b, last_res, last_z, last_c, last_o);
        end
        e.res = last_res; e.z = last_z; e.c = last_c; e.o = last_o;
        if (pend_v && pend_we) mem[pend_wa] = pend_val;
        pend_v = v; pend_we = we; pend_wa = wa; pend_val = last_res;
        q.push_back(e);
    endtask

    task automatic idle();
        cycle(0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 255), 1'b1, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        model_clear();
        repeat (n) begin
            @(negedge clk);
            chk("reset_out_valid", out_valid, 0);
        end
        chk("reset_result", ALUResult, 0);
        chk("reset_flags", {zero, carry, overflow}, 0);
        reset = 1'b0;
    endtask

    initial begin
        g_fx = 0;
        model_clear();
        do_reset(2);

        for (int i = 0; i < NREGS; i++) begin
            expect_fixed(0, 1, 0, 0);
            cycle(1, 1, i, 0, 0, 0, 0, 1);
        end

        expect_fixed(5, 0, 0, 0); cycle(1, 1, 0, 0, 5, 5, 1, 1);
        expect_fixed(4, 0, 0, 0); cycle(1, 1, 0, 0, 4, 4, 1, 1);
        idle();
        expect_fixed(9, 0, 0, 0);    cycle(1, 2, 5, 4, 6, 0, 0, 0);
        expect_fixed(1, 0, 0, 0);    cycle(1, 3, 5, 4, 6, 0, 0, 0);
        expect_fixed(8'hFF, 0, 1, 0); cycle(1, 3, 4, 5, 6, 0, 0, 0);

        expect_fixed(200, 0, 0, 0); cycle(1, 1, 0, 0, 1, 200, 1, 1);
        if (BYP) expect_fixed(44, 0, 1, 0); else expect_fixed(100, 0, 0, 0);
        cycle(1, 2, 1, 0, 2, 100, 1, 1);
        idle();

        cycle(1, 1, 0, 0, 7, 127, 1, 1);
        cycle(1, 1, 0, 0, 8, 8'hFF, 1, 1);
        cycle(1, 1, 0, 0, 9, 8'h81, 1, 1);
        cycle(1, 1, 0, 0, 10, 8'h80, 1, 1);
        idle();
        expect_fixed(8'h80, 0, 0, 1); cycle(1, 2, 7, 0, 0, 1, 0, 1);
        expect_fixed(1, 0, 0, 0);     cycle(1, 5, 8, 0, 0, 1, 0, 1);
        expect_fixed(8'h02, 0, 1, 0); cycle(1, 6, 9, 0, 0, 1, 0, 1);
        expect_fixed(8'h01, 0, 0, 0); cycle(1, 7, 10, 0, 0, 7, 0, 1);

        expect_fixed(8'h0A, 0, 0, 0); cycle(1, 4, 5, 0, 0, 8'h0F, 0, 1);
        idle();
        expect_fixed(4, 0, 0, 0);     cycle(1, 0, 4, 5, 0, 0, 0, 0);
        idle();

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else cycle(1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 255),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(); idle(); idle();

        cycle(1, 1, 0, 0, 3, 8'h55, 1, 1);
        do_reset(2);
        expect_fixed(0, 1, 0, 0); cycle(1, 1, 3, 0, 0, 0, 0, 1);
        idle(); idle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
